// File: rtl/mul_err_accum.sv
// Error-metric accumulator for an 8-bit approximate multiplier: compares each apprx
// against the exact product and accumulates count, error count, signed/absolute sums and max.
module mul_err_accum #(
  parameter int W         = 8,
  parameter int N_SAMPLES = 10000,
  parameter int CNT_W     = 32,
  parameter int SUM_W     = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [2*W-1:0]   apprx,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_count,
  output logic [CNT_W-1:0] err_count,
  output logic [SUM_W-1:0] sum_abs_ed,
  output logic [SUM_W-1:0] sum_ed,
  output logic [2*W-1:0]   max_abs_ed,
  output logic [1:0]       dbg_state
);

  localparam int P = 2 * W;

  // Handshake: a sample is taken on a rising edge where in_valid && in_ready;
  // in_ready depends only on internal state, never on in_valid.
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  state_t           state_q, state_d;
  logic             drain_q, drain_d;
  logic [CNT_W-1:0] acc_q, acc_d;

  logic [W-1:0]     a0_q, a0_d, b0_q, b0_d;
  logic [P-1:0]     ap0_q, ap0_d;
  logic             v0_q, v0_d;

  logic [P:0]       ed1_q, ed1_d;
  logic [P-1:0]     abs1_q, abs1_d;
  logic             mism1_q, mism1_d, v1_q, v1_d;

  logic [CNT_W-1:0] cnt_q, cnt_d, err_q, err_d;
  logic [SUM_W-1:0] sabs_q, sabs_d, sed_q, sed_d;
  logic [P-1:0]     max_q, max_d;

  logic             accept;
  logic [P-1:0]     exact_c;
  logic [P:0]       ed_c;

  assign in_ready = (state_q == RUN) && (acc_q < CNT_W'(N_SAMPLES));
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q == RUN) || (state_q == DRAIN);
  assign done     = (state_q == DONE);
  assign exact_c  = {{W{1'b0}}, a0_q} * {{W{1'b0}}, b0_q};
  assign ed_c     = {1'b0, exact_c} - {1'b0, ap0_q};

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    acc_d   = acc_q;
    a0_d    = a0_q;
    b0_d    = b0_q;
    ap0_d   = ap0_q;
    v0_d    = accept;
    ed1_d   = ed1_q;
    abs1_d  = abs1_q;
    mism1_d = mism1_q;
    v1_d    = v0_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    sabs_d  = sabs_q;
    sed_d   = sed_q;
    max_d   = max_q;

    case (state_q)
      IDLE:  if (start) state_d = RUN;
      RUN: begin
        if (accept) begin
          acc_d = acc_q + CNT_W'(1);
          if (acc_q == CNT_W'(N_SAMPLES - 1)) begin
            state_d = DRAIN;
            drain_d = 1'b0;
          end
        end
      end
      DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) state_d = DONE;
      end
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      a0_d  = a;
      b0_d  = b;
      ap0_d = apprx;
    end

    if (v0_q) begin
      ed1_d   = ed_c;
      abs1_d  = ed_c[P] ? (~ed_c[P-1:0] + P'(1)) : ed_c[P-1:0];
      mism1_d = (exact_c != ap0_q);
    end

    if (v1_q) begin
      cnt_d  = cnt_q + CNT_W'(1);
      err_d  = err_q + CNT_W'(mism1_q);
      sabs_d = sabs_q + SUM_W'(abs1_q);
      sed_d  = sed_q + {{(SUM_W-P-1){ed1_q[P]}}, ed1_q};
      if (abs1_q > max_q) max_d = abs1_q;
    end

    // Pipeline is empty in IDLE, so clearing never races an accumulation.
    if ((state_q == IDLE) && start) begin
      acc_d  = '0;
      cnt_d  = '0;
      err_d  = '0;
      sabs_d = '0;
      sed_d  = '0;
      max_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      drain_q <= 1'b0;
      acc_q   <= '0;
      a0_q    <= '0;
      b0_q    <= '0;
      ap0_q   <= '0;
      v0_q    <= 1'b0;
      ed1_q   <= '0;
      abs1_q  <= '0;
      mism1_q <= 1'b0;
      v1_q    <= 1'b0;
      cnt_q   <= '0;
      err_q   <= '0;
      sabs_q  <= '0;
      sed_q   <= '0;
      max_q   <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      acc_q   <= acc_d;
      a0_q    <= a0_d;
      b0_q    <= b0_d;
      ap0_q   <= ap0_d;
      v0_q    <= v0_d;
      ed1_q   <= ed1_d;
      abs1_q  <= abs1_d;
      mism1_q <= mism1_d;
      v1_q    <= v1_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      sabs_q  <= sabs_d;
      sed_q   <= sed_d;
      max_q   <= max_d;
    end
  end

  assign sample_count = cnt_q;
  assign err_count    = err_q;
  assign sum_abs_ed   = sabs_q;
  assign sum_ed       = sed_q;
  assign max_abs_ed   = max_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_mul_err_accum.sv
// Directed bench for mul_err_accum: four instances with N_SAMPLES = 4, 2, 1, 3
// share clock and reset; each runs its own hand-computed scenarios.
module tb_mul_err_accum;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start_s [4];
  logic        iv      [4];
  logic        ir      [4];
  logic        busy_s  [4];
  logic        done_s  [4];
  logic [7:0]  a_s     [4];
  logic [7:0]  b_s     [4];
  logic [15:0] ap_s    [4];
  logic [31:0] sc      [4];
  logic [31:0] ec      [4];
  logic [47:0] sa      [4];
  logic [47:0] se      [4];
  logic [15:0] mx      [4];
  logic [1:0]  st      [4];

  int vectors     = 0;
  int miscompares = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    mul_err_accum #(
      .W(8),
      .N_SAMPLES((g == 0) ? 4 : (g == 1) ? 2 : (g == 2) ? 1 : 3),
      .CNT_W(32),
      .SUM_W(48)
    ) u_dut (
      .clk(clk), .rst(rst), .start(start_s[g]), .in_valid(iv[g]), .in_ready(ir[g]),
      .a(a_s[g]), .b(b_s[g]), .apprx(ap_s[g]), .busy(busy_s[g]), .done(done_s[g]),
      .sample_count(sc[g]), .err_count(ec[g]), .sum_abs_ed(sa[g]), .sum_ed(se[g]),
      .max_abs_ed(mx[g]), .dbg_state(st[g])
    );
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int i);
    start_s[i] = 1'b1;
    step();
    start_s[i] = 1'b0;
  endtask

  task automatic send(input int i, input logic [7:0] av, input logic [7:0] bv,
                      input logic [15:0] pv);
    iv[i] = 1'b1; a_s[i] = av; b_s[i] = bv; ap_s[i] = pv;
    step();
    iv[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input string tag);
    int n = 0;
    while (!done_s[i] && n < 20) begin
      step();
      n++;
    end
    chk(tag, 64'(done_s[i]), 64'd1);
  endtask

  initial begin
    int pulses;
    for (int i = 0; i < 4; i++) begin
      start_s[i] = 1'b0; iv[i] = 1'b0; a_s[i] = '0; b_s[i] = '0; ap_s[i] = '0;
    end
    #12;
    chk("rst_state", 64'(st[0]), 64'd0);
    chk("rst_in_ready", 64'(ir[0]), 64'd0);
    chk("rst_busy", 64'(busy_s[0]), 64'd0);
    chk("rst_done", 64'(done_s[0]), 64'd0);
    chk("rst_count", 64'(sc[0]), 64'd0);
    chk("rst_sum_ed", 64'(se[1]), 64'd0);
    @(posedge clk); #1; rst = 1'b0;
    step();

    // N=4: mostly exact samples, one off by one, plus a start pulse during RUN
    do_start(0);
    chk("t1_state_run", 64'(st[0]), 64'd1);
    chk("t1_busy", 64'(busy_s[0]), 64'd1);
    chk("t1_in_ready", 64'(ir[0]), 64'd1);
    send(0, 8'd3, 8'd5, 16'd15);
    send(0, 8'd255, 8'd255, 16'd65025);
    start_s[0] = 1'b1;
    step();
    start_s[0] = 1'b0;
    chk("t1_start_ignored", 64'(st[0]), 64'd1);
    send(0, 8'd0, 8'd7, 16'd0);
    send(0, 8'd10, 8'd10, 16'd99);
    chk("t1_drain_state", 64'(st[0]), 64'd2);
    chk("t1_drain_ready", 64'(ir[0]), 64'd0);
    chk("t1_drain_busy", 64'(busy_s[0]), 64'd1);
    step();
    chk("t1_drain2_done", 64'(done_s[0]), 64'd0);
    step();
    chk("t1_done", 64'(done_s[0]), 64'd1);
    chk("t1_busy_at_done", 64'(busy_s[0]), 64'd0);
    chk("t1_sample_count", 64'(sc[0]), 64'd4);
    chk("t1_err_count", 64'(ec[0]), 64'd1);
    chk("t1_sum_abs", 64'(sa[0]), 64'd1);
    chk("t1_sum_ed", 64'(se[0]), 64'd1);
    chk("t1_max_abs", 64'(mx[0]), 64'd1);
    step();
    chk("t1_done_pulse", 64'(done_s[0]), 64'd0);
    chk("t1_idle", 64'(st[0]), 64'd0);
    chk("t1_hold_count", 64'(sc[0]), 64'd4);

    // N=2: both samples over-approximate by 4
    do_start(1);
    send(1, 8'd2, 8'd3, 16'd10);
    send(1, 8'd4, 8'd4, 16'd20);
    wait_done(1, "t2_done");
    chk("t2_err_count", 64'(ec[1]), 64'd2);
    chk("t2_sum_abs", 64'(sa[1]), 64'd8);
    chk("t2_sum_ed", 64'(se[1]), 64'h0000_FFFF_FFFF_FFF8);
    chk("t2_max_abs", 64'(mx[1]), 64'd4);

    // N=1: maximal error, then in_valid held high after the run is full
    do_start(2);
    send(2, 8'd255, 8'd255, 16'd0);
    iv[2] = 1'b1; a_s[2] = 8'd1; b_s[2] = 8'd1; ap_s[2] = 16'd0;
    chk("t3_ready_low", 64'(ir[2]), 64'd0);
    wait_done(2, "t3_done");
    chk("t3_max_abs", 64'(mx[2]), 64'd65025);
    chk("t3_sum_abs", 64'(sa[2]), 64'd65025);
    chk("t3_sum_ed", 64'(se[2]), 64'd65025);
    for (int k = 0; k < 3; k++) step();
    chk("t3_idle_ready", 64'(ir[2]), 64'd0);
    chk("t3_hold_count", 64'(sc[2]), 64'd1);
    chk("t3_hold_err", 64'(ec[2]), 64'd1);
    chk("t3_hold_sum_abs", 64'(sa[2]), 64'd65025);
    iv[2] = 1'b0;

    // N=1 again: new run must clear previous results
    do_start(2);
    chk("t6_cleared", 64'(sa[2]), 64'd0);
    send(2, 8'd2, 8'd2, 16'd5);
    wait_done(2, "t6_done");
    chk("t6_count", 64'(sc[2]), 64'd1);
    chk("t6_err_count", 64'(ec[2]), 64'd1);
    chk("t6_sum_ed", 64'(se[2]), 64'h0000_FFFF_FFFF_FFFF);
    chk("t6_sum_abs", 64'(sa[2]), 64'd1);
    chk("t6_max_abs", 64'(mx[2]), 64'd1);

    // N=3: gappy in_valid, exact samples
    do_start(3);
    a_s[3] = 8'd1; b_s[3] = 8'd1; ap_s[3] = 16'd1;
    iv[3] = 1'b1; step();
    iv[3] = 1'b0; step();
    iv[3] = 1'b1; step();
    iv[3] = 1'b0; step();
    iv[3] = 1'b1; step();
    iv[3] = 1'b0;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      if (done_s[3]) pulses++;
      step();
    end
    chk("t4_done_pulses", 64'(pulses), 64'd1);
    chk("t4_busy_low", 64'(busy_s[3]), 64'd0);
    chk("t4_count", 64'(sc[3]), 64'd3);
    chk("t4_err_count", 64'(ec[3]), 64'd0);

    // N=4: asynchronous reset in the middle of a run
    do_start(0);
    send(0, 8'd1, 8'd1, 16'd0);
    send(0, 8'd1, 8'd1, 16'd0);
    step();
    step();
    chk("t5_pre_count", 64'(sc[0]), 64'd2);
    chk("t5_pre_err", 64'(ec[0]), 64'd2);
    #3 rst = 1'b1;
    #1;
    chk("t5_rst_count", 64'(sc[0]), 64'd0);
    chk("t5_rst_err", 64'(ec[0]), 64'd0);
    chk("t5_rst_max", 64'(mx[0]), 64'd0);
    chk("t5_rst_state", 64'(st[0]), 64'd0);
    chk("t5_rst_busy", 64'(busy_s[0]), 64'd0);
    chk("t5_rst_other", 64'(sa[2]), 64'd0);
    @(posedge clk); #1; rst = 1'b0;
    step();
    do_start(0);
    send(0, 8'd6, 8'd7, 16'd42);
    send(0, 8'd9, 8'd9, 16'd81);
    send(0, 8'd0, 8'd0, 16'd0);
    send(0, 8'd200, 8'd3, 16'd600);
    wait_done(0, "t5_done");
    chk("t5_count", 64'(sc[0]), 64'd4);
    chk("t5_err_count", 64'(ec[0]), 64'd0);
    chk("t5_sum_ed", 64'(se[0]), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
